cache_nway_cfg: RTL and testbench

- Parametrised N-way set-associative, write-through, no-write-allocate cache between the picorv32 native memory port and the `memory` block.
- Successor to the fixed 2-way-random / 4-way-LRU caches: way count, set count, block size and replacement policy (LRU, random, FIFO) are all compile-time choices.
- Adds an uncached bypass region, a flush request and hit/miss statistics counters.
- Drop-in for the existing cache instance in `system`.

---
 rtl/cache_nway_cfg.sv | 252 +++++++++++++++++++++++++
 tb/tb_cache_nway_cfg.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_nway_cfg.sv
// N-way set-associative, write-through, no-write-allocate cache for the picorv32 native port.
// Geometry and replacement are parameters; includes an uncached window, flush and hit/miss counters.
module cache_nway_cfg #(
    parameter int          WAYS          = 4,
    parameter int          SETS          = 4,
    parameter int          BLOCK_WORDS   = 2,
    parameter int          REPL          = 0,
    parameter logic [31:0] UNCACHED_BASE = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid_pico,
    input  logic        mem_instr_pico,
    output logic        mem_ready_pico,
    input  logic [31:0] mem_addr_pico,
    input  logic [31:0] mem_wdata_pico,
    input  logic [3:0]  mem_wstrb_pico,
    output logic [31:0] mem_rdata_pico,
    output logic        mem_valid_mem,
    output logic        mem_instr_mem,
    input  logic        mem_ready_mem,
    output logic [31:0] mem_addr_mem,
    output logic [31:0] mem_wdata_mem,
    output logic [3:0]  mem_wstrb_mem,
    input  logic [31:0] mem_rdata_mem,
    input  logic        flush,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int OFF_BITS   = $clog2(BLOCK_WORDS);
    localparam int IDX_BITS   = $clog2(SETS);
    localparam int OFF_W      = (OFF_BITS > 0) ? OFF_BITS : 1;
    localparam int IDX_W      = (IDX_BITS > 0) ? IDX_BITS : 1;
    localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_W      = 30 - OFF_BITS - IDX_BITS;
    localparam int LINE_WORDS = SETS * BLOCK_WORDS;
    localparam int DA_W       = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FLUSH, S_TAG_RD, S_LOOKUP, S_REFILL, S_WRITE_THRU, S_BYPASS, S_RESPOND
    } state_t;

    state_t            state_reg;
    logic [31:0]       req_addr_reg, req_wdata_reg, resp_data_reg;
    logic [3:0]        req_wstrb_reg;
    logic              req_instr_reg;
    logic [OFF_W-1:0]  refill_cnt_reg;
    logic [WAY_W-1:0]  victim_reg;
    logic [IDX_W-1:0]  flush_idx_reg;
    logic [15:0]       lfsr_reg;
    logic [WAYS-1:0]   valid_reg [SETS];
    logic [WAY_W-1:0]  age_reg   [SETS][WAYS];
    logic [WAY_W-1:0]  fifo_reg  [SETS];

    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic [TAG_W-1:0]  req_tag;
    logic [DA_W-1:0]   rd_addr, data_waddr;
    logic [31:0]       block_base, hit_data, merged_word, data_wdata;
    logic [WAYS*32-1:0] way_data_flat;
    logic [WAYS-1:0]   hit_vec, data_we, tag_we;
    logic [WAY_W-1:0]  hit_way, victim, lru_upd_way;
    logic              hit, bypass, refill_last, mem_done, lru_upd_en;

    assign req_idx     = IDX_W'((req_addr_reg >> (2 + OFF_BITS)) & 32'(SETS - 1));
    assign req_off     = OFF_W'((req_addr_reg >> 2) & 32'(BLOCK_WORDS - 1));
    assign req_tag     = TAG_W'(req_addr_reg >> (2 + OFF_BITS + IDX_BITS));
    assign rd_addr     = DA_W'(int'(req_idx) * BLOCK_WORDS + int'(req_off));
    assign block_base  = req_addr_reg & ~32'(BLOCK_WORDS * 4 - 1);
    assign bypass      = (req_addr_reg >= UNCACHED_BASE);
    assign hit         = |hit_vec;
    assign refill_last = (refill_cnt_reg == OFF_W'(BLOCK_WORDS - 1));
    assign mem_done    = mem_valid_mem && mem_ready_mem;

    // Per-way tag and data storage: synchronous write, registered read.
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic [31:0]      data_mem [LINE_WORDS];
        logic [TAG_W-1:0] tag_mem  [SETS];
        logic [31:0]      data_rd;
        logic [TAG_W-1:0] tag_rd;

        always_ff @(posedge clk) begin
            if (data_we[gi]) data_mem[data_waddr] <= data_wdata;
            if (tag_we[gi])  tag_mem[req_idx]     <= req_tag;
            data_rd <= data_mem[rd_addr];
            tag_rd  <= tag_mem[req_idx];
        end

        assign hit_vec[gi] = valid_reg[req_idx][gi] && (tag_rd == req_tag);
        assign way_data_flat[gi*32 +: 32] = data_rd;
    end

    always_comb begin
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (hit_vec[w]) hit_way = WAY_W'(w);
        hit_data = way_data_flat[hit_way*32 +: 32];

        victim = '0;
        if (WAYS > 1) begin
            if (REPL == 1) begin
                victim = lfsr_reg[WAY_W-1:0];
            end else if (REPL == 2) begin
                victim = fifo_reg[req_idx];
            end else begin
                for (int w = 0; w < WAYS; w++)
                    if (age_reg[req_idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
            end
        end
        // An empty way always beats the policy choice; lowest index first.
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_reg[req_idx][w]) victim = WAY_W'(w);

        for (int b = 0; b < 4; b++)
            merged_word[b*8 +: 8] = req_wstrb_reg[b] ? req_wdata_reg[b*8 +: 8] : hit_data[b*8 +: 8];

        data_we    = '0;
        tag_we     = '0;
        data_waddr = rd_addr;
        data_wdata = merged_word;
        if (state_reg == S_LOOKUP && !bypass && hit && req_wstrb_reg != 4'b0000)
            data_we[hit_way] = 1'b1;
        if (state_reg == S_REFILL && mem_done) begin
            data_we[victim_reg] = 1'b1;
            data_waddr = DA_W'(int'(req_idx) * BLOCK_WORDS + int'(refill_cnt_reg));
            data_wdata = mem_rdata_mem;
            tag_we[victim_reg] = refill_last;
        end

        lru_upd_en  = (state_reg == S_LOOKUP && !bypass && hit) ||
                      (state_reg == S_REFILL && mem_done && refill_last);
        lru_upd_way = (state_reg == S_LOOKUP) ? hit_way : victim_reg;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg      <= S_IDLE;
            req_addr_reg   <= '0;
            req_wdata_reg  <= '0;
            req_wstrb_reg  <= '0;
            req_instr_reg  <= 1'b0;
            refill_cnt_reg <= '0;
            victim_reg     <= '0;
            flush_idx_reg  <= '0;
            resp_data_reg  <= '0;
            lfsr_reg       <= 16'hACE1;
            mem_ready_pico <= 1'b0;
            mem_rdata_pico <= '0;
            mem_valid_mem  <= 1'b0;
            mem_instr_mem  <= 1'b0;
            mem_addr_mem   <= '0;
            mem_wdata_mem  <= '0;
            mem_wstrb_mem  <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s] <= '0;
                fifo_reg[s]  <= '0;
                for (int w = 0; w < WAYS; w++) age_reg[s][w] <= WAY_W'(w);
            end
        end else begin
            lfsr_reg       <= {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
            mem_ready_pico <= 1'b0;
            mem_rdata_pico <= '0;

            if (lru_upd_en) begin
                for (int w = 0; w < WAYS; w++)
                    if (age_reg[req_idx][w] < age_reg[req_idx][lru_upd_way])
                        age_reg[req_idx][w] <= age_reg[req_idx][w] + 1'b1;
                age_reg[req_idx][lru_upd_way] <= '0;
            end

            case (state_reg)
                S_IDLE: begin
                    if (flush) begin
                        flush_idx_reg <= '0;
                        state_reg     <= S_FLUSH;
                    end else if (mem_valid_pico && !mem_ready_pico) begin
                        // A request still held during its own ready cycle is not re-accepted.
                        req_addr_reg  <= mem_addr_pico;
                        req_wdata_reg <= mem_wdata_pico;
                        req_wstrb_reg <= mem_wstrb_pico;
                        req_instr_reg <= mem_instr_pico;
                        state_reg     <= S_TAG_RD;
                    end
                end
                S_FLUSH: begin
                    valid_reg[flush_idx_reg] <= '0;
                    if (flush_idx_reg == IDX_W'(SETS - 1)) state_reg <= S_IDLE;
                    else flush_idx_reg <= flush_idx_reg + 1'b1;
                end
                S_TAG_RD: state_reg <= S_LOOKUP;
                S_LOOKUP: begin
                    mem_instr_mem <= req_instr_reg;
                    if (!bypass) begin
                        if (hit && hit_count != 32'hFFFF_FFFF)   hit_count  <= hit_count + 1'b1;
                        if (!hit && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 1'b1;
                    end
                    if (bypass || req_wstrb_reg != 4'b0000) begin
                        mem_valid_mem <= 1'b1;
                        mem_addr_mem  <= {req_addr_reg[31:2], 2'b00};
                        mem_wdata_mem <= req_wdata_reg;
                        mem_wstrb_mem <= req_wstrb_reg;
                        state_reg     <= bypass ? S_BYPASS : S_WRITE_THRU;
                    end else if (hit) begin
                        resp_data_reg <= hit_data;
                        state_reg     <= S_RESPOND;
                    end else begin
                        victim_reg     <= victim;
                        refill_cnt_reg <= '0;
                        mem_valid_mem  <= 1'b1;
                        mem_addr_mem   <= block_base;
                        mem_wdata_mem  <= '0;
                        mem_wstrb_mem  <= '0;
                        state_reg      <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_done) begin
                        mem_valid_mem <= 1'b0;
                        if (refill_cnt_reg == req_off) resp_data_reg <= mem_rdata_mem;
                        if (refill_last) begin
                            valid_reg[req_idx][victim_reg] <= 1'b1;
                            fifo_reg[req_idx] <= WAY_W'((int'(fifo_reg[req_idx]) + 1) % WAYS);
                            state_reg <= S_RESPOND;
                        end else begin
                            refill_cnt_reg <= refill_cnt_reg + 1'b1;
                        end
                    end else if (!mem_valid_mem) begin
                        mem_valid_mem <= 1'b1;
                        mem_addr_mem  <= block_base | (32'(refill_cnt_reg) << 2);
                    end
                end
                S_WRITE_THRU, S_BYPASS: begin
                    if (mem_ready_mem) begin
                        mem_valid_mem <= 1'b0;
                        mem_wstrb_mem <= '0;
                        resp_data_reg <= (state_reg == S_BYPASS && req_wstrb_reg == 4'b0000)
                                         ? mem_rdata_mem : 32'h0;
                        state_reg     <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    mem_ready_pico <= 1'b1;
                    mem_rdata_pico <= resp_data_reg;
                    state_reg      <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_nway_cfg.sv
// Self-checking bench for cache_nway_cfg: behavioural memory, per-scenario tasks,
// and a queue of expected read data compared when the cache answers.
module tb_cache_nway_cfg;
    logic        clk, resetn;
    logic        mem_valid_pico, mem_instr_pico, mem_ready_pico;
    logic [31:0] mem_addr_pico, mem_wdata_pico, mem_rdata_pico;
    logic [3:0]  mem_wstrb_pico;
    logic        mem_valid_mem, mem_instr_mem, mem_ready_mem;
    logic [31:0] mem_addr_mem, mem_wdata_mem, mem_rdata_mem;
    logic [3:0]  mem_wstrb_mem;
    logic        flush;
    logic [31:0] hit_count, miss_count;

    int errors = 0;
    int checks = 0;
    int mem_reads = 0;
    int mem_writes = 0;
    logic [31:0] rd_q [$];
    logic [31:0] exp_q [$];
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] last_w_addr;
    logic [3:0]  last_w_strb;

    cache_nway_cfg dut (
        .clk(clk), .resetn(resetn),
        .mem_valid_pico(mem_valid_pico), .mem_instr_pico(mem_instr_pico),
        .mem_ready_pico(mem_ready_pico), .mem_addr_pico(mem_addr_pico),
        .mem_wdata_pico(mem_wdata_pico), .mem_wstrb_pico(mem_wstrb_pico),
        .mem_rdata_pico(mem_rdata_pico),
        .mem_valid_mem(mem_valid_mem), .mem_instr_mem(mem_instr_mem),
        .mem_ready_mem(mem_ready_mem), .mem_addr_mem(mem_addr_mem),
        .mem_wdata_mem(mem_wdata_mem), .mem_wstrb_mem(mem_wstrb_mem),
        .mem_rdata_mem(mem_rdata_mem),
        .flush(flush), .hit_count(hit_count), .miss_count(miss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] wa;
        wa = a & ~32'h3;
        return mem_model.exists(wa) ? mem_model[wa] : 32'hDEAD0000 + wa;
    endfunction

    // Memory answers a request two sampling cycles after it appears.
    initial begin
        int wait_cnt;
        logic [31:0] w;
        wait_cnt = 0;
        mem_ready_mem = 1'b0;
        mem_rdata_mem = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!resetn || !mem_valid_mem) begin
                mem_ready_mem = 1'b0;
                wait_cnt = 0;
            end else if (mem_ready_mem) begin
                mem_ready_mem = 1'b0;
            end else begin
                wait_cnt++;
                if (wait_cnt >= 2) begin
                    wait_cnt = 0;
                    mem_ready_mem = 1'b1;
                    if (mem_wstrb_mem != 4'b0000) begin
                        w = mem_rd(mem_addr_mem);
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb_mem[b]) w[b*8 +: 8] = mem_wdata_mem[b*8 +: 8];
                        mem_model[mem_addr_mem & ~32'h3] = w;
                        last_w_addr = mem_addr_mem;
                        last_w_strb = mem_wstrb_mem;
                        mem_writes++;
                    end else begin
                        mem_rdata_mem = mem_rd(mem_addr_mem);
                        rd_q.push_back(mem_addr_mem);
                        mem_reads++;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        resetn = 1'b0;
        mem_valid_pico = 1'b0;
        mem_instr_pico = 1'b0;
        mem_addr_pico = '0;
        mem_wdata_pico = '0;
        mem_wstrb_pico = '0;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        mem_model.delete();
        rd_q.delete();
        @(posedge clk);
        #1;
    endtask

    // One CPU transaction; expected rdata is queued at issue and popped at ready.
    task automatic cpu_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, output int lat, output int nrd,
                              output int nwr, output logic [31:0] rdata);
        int rd0, wr0;
        logic [31:0] exp;
        rd0 = mem_reads;
        wr0 = mem_writes;
        exp_q.push_back(wstrb == 4'b0000 ? mem_rd(addr) : 32'h0);
        mem_addr_pico = addr;
        mem_wdata_pico = wdata;
        mem_wstrb_pico = wstrb;
        mem_valid_pico = 1'b1;
        @(posedge clk);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (mem_ready_pico) break;
        end
        exp = exp_q.pop_front();
        rdata = mem_rdata_pico;
        checks++;
        if (!mem_ready_pico) begin
            errors++;
            $display("FAIL timeout addr=%h: mem_ready_pico never rose", addr);
        end else if (rdata !== exp) begin
            errors++;
            $display("FAIL rdata addr=%h: got %h expected %h", addr, rdata, exp);
        end
        mem_valid_pico = 1'b0;
        mem_wstrb_pico = 4'b0000;
        @(posedge clk);
        #1;
        nrd = mem_reads - rd0;
        nwr = mem_writes - wr0;
        $display("txn addr=%h wstrb=%b wdata=%h rdata=%h lat=%0d mem_rd=%0d mem_wr=%0d hits=%0d misses=%0d",
                 addr, wstrb, wdata, rdata, lat, nrd, nwr, hit_count, miss_count);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        mem_valid_pico = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_ready_pico, mem_valid_mem, mem_wstrb_mem} !== 6'b0 || mem_rdata_pico !== 32'h0 ||
            mem_addr_mem !== 32'h0 || hit_count !== 32'h0 || miss_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b valid_mem=%b rdata=%h addr=%h hits=%h misses=%h required all zero",
                     mem_ready_pico, mem_valid_mem, mem_rdata_pico, mem_addr_mem, hit_count, miss_count);
        end
        do_reset();
    endtask

    task automatic test_hit_miss();
        int lat, nrd, nwr;
        logic [31:0] rdata, a0, a1;
        do_reset();
        cpu_access(32'h100, 32'h0, 4'b0000, lat, nrd, nwr, rdata);
        a0 = (rd_q.size() > 0) ? rd_q[0] : 32'hFFFF_FFFF;
        a1 = (rd_q.size() > 1) ? rd_q[1] : 32'hFFFF_FFFF;
        checks++;
        if (rd_q.size() != 2 || a0 !== 32'h100 || a1 !== 32'h104) begin
            errors++;
            $display("FAIL refill_addrs: got n=%0d %h %h required n=2 00000100 00000104", rd_q.size(), a0, a1);
        end
        checks++;
        if (rdata !== 32'hDEAD0100) begin
            errors++;
            $display("FAIL miss_rdata: got %h required DEAD0100", rdata);
        end
        checks++;
        if (miss_count !== 32'd1) begin
            errors++;
            $display("FAIL miss_count_1: got %0d required 1", miss_count);
        end
        cpu_access(32'h100, 32'h0, 4'b0000, lat, nrd, nwr, rdata);
        checks++;
        if (nrd != 0 || lat != 3) begin
            errors++;
            $display("FAIL hit_latency: got mem_rd=%0d lat=%0d required mem_rd=0 lat=3", nrd, lat);
        end
        checks++;
        if (hit_count !== 32'd1) begin
            errors++;
            $display("FAIL hit_count_1: got %0d required 1", hit_count);
        end
    endtask

    task automatic test_lru();
        int lat, nrd, nwr;
        logic [31:0] rdata;
        logic [31:0] addrs [7];
        int exp_rd [7];
        addrs = '{32'h000, 32'h020, 32'h040, 32'h060, 32'h000, 32'h080, 32'h000};
        exp_rd = '{2, 2, 2, 2, 0, 2, 0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cpu_access(addrs[i], 32'h0, 4'b0000, lat, nrd, nwr, rdata);
            checks++;
            if (nrd != exp_rd[i]) begin
                errors++;
                $display("FAIL lru_step%0d addr=%h: got mem_rd=%0d required %0d", i, addrs[i], nrd, exp_rd[i]);
            end
        end
        cpu_access(32'h020, 32'h0, 4'b0000, lat, nrd, nwr, rdata);
        checks++;
        if (nrd != 2) begin
            errors++;
            $display("FAIL lru_evicted_020: got mem_rd=%0d required 2", nrd);
        end
        checks++;
        if (hit_count !== 32'd2 || miss_count !== 32'd6) begin
            errors++;
            $display("FAIL lru_counters: got hits=%0d misses=%0d required 2 and 6", hit_count, miss_count);
        end
    endtask

    task automatic test_write();
        int lat, nrd, nwr;
        logic [31:0] rdata;
        do_reset();
        cpu_access(32'h100, 32'h0, 4'b0000, lat, nrd, nwr, rdata);
        cpu_access(32'h100, 32'h11223344, 4'b0011, lat, nrd, nwr, rdata);
        checks++;
        if (nwr != 1 || nrd != 0 || last_w_strb !== 4'b0011 || last_w_addr !== 32'h100) begin
            errors++;
            $display("FAIL write_hit: got wr=%0d rd=%0d strb=%b addr=%h required 1 0 0011 00000100",
                     nwr, nrd, last_w_strb, last_w_addr);
        end
        cpu_access(32'h100, 32'h0, 4'b0000, lat, nrd, nwr, rdata);
        checks++;
        if (rdata !== 32'hDEAD3344 || nrd != 0) begin
            errors++;
            $display("FAIL merged_read: got %h mem_rd=%0d required DEAD3344 mem_rd=0", rdata, nrd);
        end
        cpu_access(32'h300, 32'h55667788, 4'b1111, lat, nrd, nwr, rdata);
        cpu_access(32'h300, 32'h0, 4'b0000, lat, nrd, nwr, rdata);
        checks++;
        if (nrd != 2 || rdata !== 32'h55667788) begin
            errors++;
            $display("FAIL no_write_allocate: got mem_rd=%0d rdata=%h required 2 55667788", nrd, rdata);
        end
        checks++;
        if (hit_count !== 32'd2 || miss_count !== 32'd3) begin
            errors++;
            $display("FAIL write_counters: got hits=%0d misses=%0d required 2 and 3", hit_count, miss_count);
        end
    endtask

    task automatic test_bypass();
        int lat, nrd, nwr, total_wr;
        logic [31:0] rdata;
        do_reset();
        total_wr = 0;
        for (int i = 0; i < 2; i++) begin
            cpu_access(32'h1000_0000, 32'h41, 4'b1111, lat, nrd, nwr, rdata);
            total_wr += nwr;
        end
        checks++;
        if (total_wr != 2 || last_w_addr !== 32'h1000_0000) begin
            errors++;
            $display("FAIL bypass_writes: got %0d last_addr=%h required 2 10000000", total_wr, last_w_addr);
        end
        cpu_access(32'h1000_0000, 32'h0, 4'b0000, lat, nrd, nwr, rdata);
        cpu_access(32'h1000_0000, 32'h0, 4'b0000, lat, nrd, nwr, rdata);
        checks++;
        if (nrd != 1 || rdata !== 32'h41) begin
            errors++;
            $display("FAIL bypass_read: got mem_rd=%0d rdata=%h required 1 00000041", nrd, rdata);
        end
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++;
            $display("FAIL bypass_counters: got hits=%0d misses=%0d required 0 and 0", hit_count, miss_count);
        end
    endtask

    task automatic test_flush();
        int lat, nrd, nwr, n, rd0;
        logic [31:0] rdata, exp;
        logic [31:0] fills [4];
        fills = '{32'h000, 32'h020, 32'h040, 32'h060};
        do_reset();
        for (int i = 0; i < 4; i++) cpu_access(fills[i], 32'h0, 4'b0000, lat, nrd, nwr, rdata);
        cpu_access(32'h000, 32'h0, 4'b0000, lat, nrd, nwr, rdata);
        rd0 = mem_reads;
        exp_q.push_back(mem_rd(32'h000));
        mem_addr_pico = 32'h000;
        mem_wstrb_pico = 4'b0000;
        mem_valid_pico = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (mem_ready_pico) break;
            n++;
        end
        exp = exp_q.pop_front();
        checks++;
        if (!mem_ready_pico || mem_rdata_pico !== exp) begin
            errors++;
            $display("FAIL flush_read: ready=%b rdata=%h required ready=1 rdata=%h", mem_ready_pico, mem_rdata_pico, exp);
        end
        mem_valid_pico = 1'b0;
        @(posedge clk);
        #1;
        $display("txn flush+read addr=00000000 rdata=%h cycles=%0d mem_rd=%0d hits=%0d misses=%0d",
                 exp, n, mem_reads - rd0, hit_count, miss_count);
        checks++;
        if (mem_reads - rd0 != 2 || n < 4 + 3) begin
            errors++;
            $display("FAIL flush_miss: got mem_rd=%0d cycles=%0d required mem_rd=2 cycles>=7", mem_reads - rd0, n);
        end
        checks++;
        if (hit_count !== 32'd1 || miss_count !== 32'd5) begin
            errors++;
            $display("FAIL flush_counters: got hits=%0d misses=%0d required 1 and 5", hit_count, miss_count);
        end
    endtask

    task automatic test_reset_refill();
        int lat, nrd, nwr, n, rd0;
        logic [31:0] rdata;
        do_reset();
        rd0 = mem_reads;
        mem_addr_pico = 32'h100;
        mem_wstrb_pico = 4'b0000;
        mem_valid_pico = 1'b1;
        n = 0;
        while (mem_reads == rd0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mem_reads == rd0) begin
            errors++;
            $display("FAIL refill_start: no memory read within %0d cycles", n);
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (mem_valid_mem !== 1'b1 || mem_addr_mem !== 32'h104) begin
            errors++;
            $display("FAIL second_word_req: valid=%b addr=%h required 1 00000104", mem_valid_mem, mem_addr_mem);
        end
        resetn = 1'b0;
        mem_valid_pico = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_valid_mem !== 1'b0 || mem_ready_pico !== 1'b0) begin
            errors++;
            $display("FAIL abort_on_reset: valid_mem=%b ready=%b required 0 0", mem_valid_mem, mem_ready_pico);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        cpu_access(32'h100, 32'h0, 4'b0000, lat, nrd, nwr, rdata);
        checks++;
        if (nrd != 2 || rdata !== 32'hDEAD0100 || miss_count !== 32'd1 || hit_count !== 32'd0) begin
            errors++;
            $display("FAIL refill_after_reset: got mem_rd=%0d rdata=%h misses=%0d hits=%0d required 2 DEAD0100 1 0",
                     nrd, rdata, miss_count, hit_count);
        end
    endtask

    initial begin
        test_reset();
        test_hit_miss();
        test_lru();
        test_write();
        test_bypass();
        test_flush();
        test_reset_refill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
